instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Fetch front-end that sits directly upstream of the instruction memory and feeds the decode stage. It owns the fetch PC, drives the memory's combinational read address, and captures each returned word with its PC into a small prefetch queue. Decode pops entries over a valid/ready handshake. A redirect from execute flushes the queue and restarts fetch at a new PC.

## Interface
- `RESET_PC`, default 32'h0: fetch PC loaded on reset.
- `DEPTH`, default 4: queue entries; power of two, at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fetch_en`  in  1  when low, no enqueue and fetch PC holds.
- `imem_addr`  out  32  byte address to instruction memory; equals fetch PC.
- `imem_dout`  in  32  instruction word returned combinationally for `imem_addr`.
- `redirect_valid`  in  1  flush and restart request.
- `redirect_pc`  in  32  new fetch PC.
- `out_valid`  out  1  head entry available to decode.
- `out_ready`  in  1  decode accepts head entry.
- `out_inst`  out  32  head instruction.
- `out_pc`  out  32  PC of head instruction.
- `count`  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Reset (`reset`=0, asynchronous): fetch PC = `RESET_PC`, `count`=0, read/write pointers=0, `out_valid`=0, `out_inst`=0, `out_pc`=0.
- Enqueue condition: `fetch_en` && !`redirect_valid` && `count` < DEPTH.
  - On enqueue: {fetch PC, `imem_dout`} is written at the write pointer.
  - Fetch PC advances by 4.
  - The write pointer advances.
- Full queue: no enqueue and fetch PC holds. There is no same-cycle pop-then-enqueue bypass.
- Pop condition: `out_valid` && `out_ready`. On pop the read pointer advances.
- `out_valid` = (`count` != 0) && !`redirect_valid`.
- `out_inst` and `out_pc` show the head entry when `count` != 0, and 0 when the queue is empty.
- Simultaneous enqueue and pop: `count` is unchanged and both pointers advance.
- Redirect has priority over everything:
  - `count`, the read pointer and the write pointer go to 0.
  - Fetch PC = `redirect_pc` & ~32'h3; the low bits are silently cleared.
  - No enqueue and no pop that cycle.
  - Redirect held over several cycles keeps the queue empty, and the last PC wins.
- Arithmetic:
  - Fetch PC increments modulo 2^32: 32'hFFFFFFFC + 4 = 0.
  - Pointers are $clog2(DEPTH) bits wide and wrap naturally.
  - `count` is one bit wider than the pointers, so it can represent DEPTH.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

## Timing
- `imem_addr` is a registered output, so there is no combinational path from `out_ready` or `redirect_valid` to `imem_addr`.
- Fetch-to-decode latency is 1 cycle: a word enqueued at edge N is visible with `out_valid`=1 after edge N.
- First edge after reset release enqueues the word at `RESET_PC`. `out_valid` rises after that edge.
- Redirect asserted for the cycle ending at edge N:
  - The new-PC word is enqueued at edge N+1.
  - That word is valid at the output after edge N+1.
- Steady state with `out_ready`=1 and `fetch_en`=1: one instruction per cycle after warm-up.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_entry_t` = {pc[31:0], inst[31:0]}.
  - `INST_NOP` = 32'h00000013.
  - `PC_STEP` = 4.
- Sub-module `fetch_fifo`: a DEPTH x `fetch_entry_t` register FIFO.
  - Inputs: push, pop, flush.
  - Outputs: head, count, full, empty.
  - Uses the same asynchronous active-low reset.
- Top level holds the fetch PC register plus enqueue, pop and redirect logic.

## Test plan
- Reset release, with memory word k = 32'h1000+k and `out_ready`=1:
  - Outputs are 0 during reset.
  - Then (pc, inst) = (0, 32'h1000), (4, 32'h1001), (8, 32'h1002) on consecutive cycles.
- `out_ready`=0 with DEPTH=4:
  - `count` reaches 4 after 4 edges.
  - `imem_addr` holds at 16.
  - Raising `out_ready` drains PCs 0, 4, 8, 12 in order, then 16.
- Redirect to 32'h203 while 3 entries are queued:
  - The next cycle shows `count`=0 and `out_valid`=0.
  - The next delivered entry is pc=32'h200.
  - No stale PC ever appears.
- Fetch PC at 32'hFFFFFFF8:
  - Delivered PCs are FFFFFFF8, FFFFFFFC, 0.
- `fetch_en`=0 for 3 cycles mid-stream:
  - The queue drains to empty and `out_valid`=0.
  - `imem_addr` is constant.
  - Resume continues at the next sequential PC.
- `reset` pulsed low between clock edges while the queue is full:
  - `out_valid`=0 and `count`=0 immediately.
  - After release, the first delivered entry is pc=`RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry register FIFO of fetch entries; flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // An empty queue presents zeros rather than whatever stale entry sits at rd_ptr.
  assign head  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front-end: owns the fetch PC, drives imem, and queues (pc, inst) pairs for decode.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_en,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_dout,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [31:0]              out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         enq;
  logic         pop;
  logic         full;
  logic         empty;
  fetch_entry_t enq_entry;
  fetch_entry_t head;

  assign enq       = fetch_en && !redirect_valid && !full;
  assign out_valid = !empty && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign enq_entry = '{pc: fetch_pc_q, inst: imem_dout};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'h3;
    end else if (enq) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (enq),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (enq_entry),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign imem_addr = fetch_pc_q;
  assign out_inst  = head.inst;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue; memory word at byte address A is 32'h1000 + (A >> 2).
module tb_instr_fetch_queue;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] addr_hold;

  instr_fetch_queue #(
    .RESET_PC (32'h0),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .count          (count)
  );

  always #5 clk = ~clk;

  // Misaligned fetches never occur; the NOP fallback just keeps the model total.
  assign imem_dout = (imem_addr[1:0] != 2'b00) ? INST_NOP : 32'h1000 + (imem_addr >> 2);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_inst"}, out_inst, inst);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset          = 1'b0;
    fetch_en       = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_inst", out_inst, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    reset = 1'b1;

    // Streaming after reset release
    tick();
    check_head("s0", 32'h0, 32'h1000);
    check("s0_count", 32'(count), 32'd1);
    tick();
    check_head("s1", 32'h4, 32'h1001);
    tick();
    check_head("s2", 32'h8, 32'h1002);
    check("s2_count", 32'(count), 32'd1);

    // Fill with out_ready low
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    check("f_flushed", 32'(count), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("f_count4", 32'(count), 32'd4);
    check("f_addr16", imem_addr, 32'h10);
    tick();
    check("f_count_hold", 32'(count), 32'd4);
    check("f_addr_hold", imem_addr, 32'h10);
    check_head("f_h0", 32'h0, 32'h1000);
    out_ready = 1'b1;
    tick();
    check("d_count3", 32'(count), 32'd3);
    check_head("d_h4", 32'h4, 32'h1001);
    tick();
    check_head("d_h8", 32'h8, 32'h1002);
    tick();
    check_head("d_h12", 32'hC, 32'h1003);
    tick();
    check_head("d_h16", 32'h10, 32'h1004);

    // Redirect with three queued entries
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("r_count3", 32'(count), 32'd3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    #1;
    check("r_valid_during", 32'(out_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    #1;
    check("r_count0", 32'(count), 32'd0);
    check("r_valid0", 32'(out_valid), 32'd0);
    check("r_addr", imem_addr, 32'h200);
    tick();
    check_head("r_h200", 32'h200, 32'h1080);
    check("r_count1", 32'(count), 32'd1);
    tick();
    check_head("r_h204", 32'h204, 32'h1081);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    tick();
    check_head("w_f8", 32'hFFFF_FFF8, 32'h4000_0FFE);
    tick();
    check_head("w_fc", 32'hFFFF_FFFC, 32'h4000_0FFF);
    tick();
    check_head("w_0", 32'h0, 32'h1000);

    // fetch_en low for three cycles
    fetch_en  = 1'b0;
    addr_hold = imem_addr;
    check("e_addr_before", imem_addr, 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("e_valid", 32'(out_valid), 32'd0);
      check("e_count", 32'(count), 32'd0);
      check("e_addr", imem_addr, addr_hold);
    end
    fetch_en = 1'b1;
    tick();
    check_head("e_resume", 32'h4, 32'h1001);

    // Asynchronous reset while full
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("a_full", 32'(count), 32'd4);
    reset = 1'b0;
    #1;
    check("a_valid", 32'(out_valid), 32'd0);
    check("a_count", 32'(count), 32'd0);
    check("a_pc", out_pc, 32'h0);
    check("a_addr", imem_addr, 32'h0);
    #1;
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    check_head("a_first", 32'h0, 32'h1000);
    tick();
    check_head("a_second", 32'h4, 32'h1001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
